// File: rtl/ctrl_pkg.sv
// Shared definitions for the 4-bit-address computer's controller/sequencer.
// Holds the opcode map, the T-state one-hot codes, the sequencer state type
// and the bit positions of the control word.
// Ports: none (package).
package ctrl_pkg;

  // Opcodes (IR upper nibble)
  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JC  = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // T-state one-hot codes as presented on the tstate output
  localparam logic [5:0] T1_OH = 6'b000001;
  localparam logic [5:0] T2_OH = 6'b000010;
  localparam logic [5:0] T3_OH = 6'b000100;
  localparam logic [5:0] T4_OH = 6'b001000;
  localparam logic [5:0] T5_OH = 6'b010000;
  localparam logic [5:0] T6_OH = 6'b100000;

  // The low six bits of each state are its tstate code, so tstate is a
  // plain slice of the state register and reads all zeros when halted.
  typedef enum logic [6:0] {
    ST_T1     = {1'b0, T1_OH},
    ST_T2     = {1'b0, T2_OH},
    ST_T3     = {1'b0, T3_OH},
    ST_T4     = {1'b0, T4_OH},
    ST_T5     = {1'b0, T5_OH},
    ST_T6     = {1'b0, T6_OH},
    ST_HALTED = 7'b1000000
  } state_t;

  // Control-word bit positions
  localparam int CW_PC_EN   = 0;
  localparam int CW_PC_OE   = 1;
  localparam int CW_PC_WE   = 2;
  localparam int CW_MAR_WE  = 3;
  localparam int CW_RAM_OE  = 4;
  localparam int CW_IR_WE   = 5;
  localparam int CW_IR_OE   = 6;
  localparam int CW_A_WE    = 7;
  localparam int CW_A_OE    = 8;
  localparam int CW_B_WE    = 9;
  localparam int CW_ALU_SUB = 10;
  localparam int CW_ALU_OE  = 11;
  localparam int CW_OUT_WE  = 12;
  localparam int CW_W       = 13;

  typedef logic [CW_W-1:0] cw_t;

  // Single-bit mask for one control-word position
  function automatic cw_t cw_bit(input int idx);
    cw_t m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  // Strobes that change state somewhere in the datapath; these only fire
  // on cycles where the sequencer actually advances.
  localparam cw_t CW_STATE_MASK = cw_bit(CW_PC_EN) | cw_bit(CW_PC_WE) |
                                  cw_bit(CW_MAR_WE) | cw_bit(CW_IR_WE) |
                                  cw_bit(CW_A_WE) | cw_bit(CW_B_WE) |
                                  cw_bit(CW_OUT_WE);

endpackage

// File: rtl/control_sequencer_step_edge.sv
// step_edge: rising-edge detector for the single-step request.
// Ports:
//   CLK   - system clock
//   RESET - synchronous active-high reset, clears the history register
//   step  - single-step request level
//   pulse - high for the one cycle in which step is 1 and was 0 last cycle
module step_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic step,
  output logic pulse
);

  logic step_q;

  always_ff @(posedge CLK) begin
    if (RESET) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign pulse = step & ~step_q;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: T-state ring plus instruction decode for the
// 4-bit-address computer. Produces the per-cycle control word from the
// current T-state, the IR opcode and the ALU flags.
// Ports:
//   CLK, RESET            - clock, synchronous active-high reset
//   opcode                - IR upper nibble, stable from T4 onward
//   carry_flag, zero_flag - ALU flags from the last ADD/SUB
//   run, step             - free-run enable / single-step request level
//   pc_en .. out_we       - control word (bus enables and load strobes)
//   halted                - high while halted
//   tstate                - one-hot T-state, zero when halted
module control_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_T    = 6
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  input  logic                run,
  input  logic                step,
  output logic                pc_en,
  output logic                pc_oe,
  output logic                pc_we,
  output logic                mar_we,
  output logic                ram_oe,
  output logic                ir_we,
  output logic                ir_oe,
  output logic                a_we,
  output logic                a_oe,
  output logic                b_we,
  output logic                alu_sub,
  output logic                alu_oe,
  output logic                out_we,
  output logic                halted,
  output logic [NUM_T-1:0]    tstate
);

  if (NUM_T != 6) begin : g_bad_num_t
    $error("control_sequencer: NUM_T must be 6");
  end

  state_t state;
  logic   step_pulse;
  logic   adv;
  cw_t    cw_raw;
  cw_t    cw;

  step_edge u_step_edge (
    .CLK   (CLK),
    .RESET (RESET),
    .step  (step),
    .pulse (step_pulse)
  );

  assign adv = run | step_pulse;

  // T-state ring; HALTED is only left through RESET
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_T1;
    end else if (adv) begin
      unique case (state)
        ST_T1:     state <= ST_T2;
        ST_T2:     state <= ST_T3;
        ST_T3:     state <= ST_T4;
        ST_T4:     state <= (opcode == OP_HLT) ? ST_HALTED : ST_T5;
        ST_T5:     state <= ST_T6;
        ST_T6:     state <= ST_T1;
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_T1;
      endcase
    end
  end

  // Decode table: fetch in T1-T3, per-opcode execute in T4-T6
  always_comb begin
    cw_raw = '0;
    unique case (state)
      ST_T1: cw_raw = cw_bit(CW_PC_OE) | cw_bit(CW_MAR_WE);
      ST_T2: cw_raw = cw_bit(CW_PC_EN);
      ST_T3: cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_IR_WE);
      ST_T4: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_MAR_WE);
          OP_JMP:                 cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_WE);
          OP_JC:  if (carry_flag) cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_WE);
          OP_JZ:  if (zero_flag)  cw_raw = cw_bit(CW_IR_OE) | cw_bit(CW_PC_WE);
          OP_OUT:                 cw_raw = cw_bit(CW_A_OE) | cw_bit(CW_OUT_WE);
          default:                cw_raw = '0;
        endcase
      end
      ST_T5: begin
        case (opcode)
          OP_LDA:  cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_A_WE);
          OP_ADD:  cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_B_WE);
          OP_SUB:  cw_raw = cw_bit(CW_RAM_OE) | cw_bit(CW_B_WE) | cw_bit(CW_ALU_SUB);
          default: cw_raw = '0;
        endcase
      end
      ST_T6: begin
        case (opcode)
          OP_ADD:  cw_raw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_WE);
          OP_SUB:  cw_raw = cw_bit(CW_ALU_OE) | cw_bit(CW_A_WE) | cw_bit(CW_ALU_SUB);
          default: cw_raw = '0;
        endcase
      end
      default: cw_raw = '0;
    endcase
  end

  // Load strobes only fire on advancing cycles so a held state never
  // double-loads; everything is silenced while RESET is asserted.
  always_comb begin
    cw = cw_raw & ~(CW_STATE_MASK & {CW_W{~adv}});
    if (RESET) cw = '0;
  end

  assign pc_en   = cw[CW_PC_EN];
  assign pc_oe   = cw[CW_PC_OE];
  assign pc_we   = cw[CW_PC_WE];
  assign mar_we  = cw[CW_MAR_WE];
  assign ram_oe  = cw[CW_RAM_OE];
  assign ir_we   = cw[CW_IR_WE];
  assign ir_oe   = cw[CW_IR_OE];
  assign a_we    = cw[CW_A_WE];
  assign a_oe    = cw[CW_A_OE];
  assign b_we    = cw[CW_B_WE];
  assign alu_sub = cw[CW_ALU_SUB];
  assign alu_oe  = cw[CW_ALU_OE];
  assign out_we  = cw[CW_OUT_WE];

  assign halted = (state == ST_HALTED) & ~RESET;
  assign tstate = state[NUM_T-1:0];

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed scenarios followed by random
// run/step/opcode/flag/reset stimulus, checked by a scoreboard against an
// instruction-level reference model.
module tb_control_sequencer;

  logic       CLK;
  logic       RESET;
  logic [3:0] opcode;
  logic       carry_flag, zero_flag, run, step;
  logic       pc_en, pc_oe, pc_we, mar_we, ram_oe, ir_we, ir_oe;
  logic       a_we, a_oe, b_we, alu_sub, alu_oe, out_we, halted;
  logic [5:0] tstate;

  control_sequencer #(.OPCODE_W(4), .NUM_T(6)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .run(run), .step(step),
    .pc_en(pc_en), .pc_oe(pc_oe), .pc_we(pc_we), .mar_we(mar_we),
    .ram_oe(ram_oe), .ir_we(ir_we), .ir_oe(ir_oe), .a_we(a_we),
    .a_oe(a_oe), .b_we(b_we), .alu_sub(alu_sub), .alu_oe(alu_oe),
    .out_we(out_we), .halted(halted), .tstate(tstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic pc_en, pc_oe, pc_we, mar_we, ram_oe, ir_we, ir_oe;
    logic a_we, a_oe, b_we, alu_sub, alu_oe, out_we, halted;
    logic [5:0] tstate;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Reference model: instruction step counter 1..6 and a halt flag
  int   m_t;
  bit   m_halt;
  bit   m_stepq;

  task automatic cycle(input bit rst, input bit r, input bit s,
                       input logic [3:0] op, input bit c, input bit z);
    obs_t e;
    bit   adv;
    RESET = rst; run = r; step = s; opcode = op; carry_flag = c; zero_flag = z;
    adv = r | (s & ~m_stepq);
    e = '0;
    e.tstate = m_halt ? 6'd0 : 6'(1 << (m_t - 1));
    if (!rst) begin
      if (m_halt) begin
        e.halted = 1'b1;
      end else begin
        case (m_t)
          1: begin e.pc_oe = 1'b1; e.mar_we = adv; end          // address <- PC
          2: e.pc_en = adv;                                    // PC increment
          3: begin e.ram_oe = 1'b1; e.ir_we = adv; end          // IR <- memory
          4: case (op)
               4'h0, 4'h1, 4'h2: begin e.ir_oe = 1'b1; e.mar_we = adv; end
               4'h3: begin e.ir_oe = 1'b1; e.pc_we = adv; end
               4'h4: if (c) begin e.ir_oe = 1'b1; e.pc_we = adv; end
               4'h5: if (z) begin e.ir_oe = 1'b1; e.pc_we = adv; end
               4'hE: begin e.a_oe = 1'b1; e.out_we = adv; end
               default: ;
             endcase
          5: case (op)
               4'h0: begin e.ram_oe = 1'b1; e.a_we = adv; end
               4'h1: begin e.ram_oe = 1'b1; e.b_we = adv; end
               4'h2: begin e.ram_oe = 1'b1; e.b_we = adv; e.alu_sub = 1'b1; end
               default: ;
             endcase
          default: case (op)
               4'h1: begin e.alu_oe = 1'b1; e.a_we = adv; end
               4'h2: begin e.alu_oe = 1'b1; e.a_we = adv; e.alu_sub = 1'b1; end
               default: ;
             endcase
        endcase
      end
    end
    exp_q.push_back(e);
    @(posedge CLK);
    if (rst) begin
      m_t = 1; m_halt = 1'b0; m_stepq = 1'b0;
    end else begin
      m_stepq = s;
      if (!m_halt && adv) begin
        if (m_t == 4 && op == 4'hF) m_halt = 1'b1;
        else                        m_t = (m_t % 6) + 1;
      end
    end
    #1;
  endtask

  // Monitor: one expected entry per presented cycle
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {pc_en, pc_oe, pc_we, mar_we, ram_oe, ir_we, ir_oe,
               a_we, a_oe, b_we, alu_sub, alu_oe, out_we, halted, tstate};
      cyc++;
      n_tests++;
      if (mon_a[19:6] !== mon_e[19:6]) begin
        n_fail++;
        $display("FAIL ctrl cyc=%0d actual=%b required=%b (pc_en..out_we,halted)",
                 cyc, mon_a[19:6], mon_e[19:6]);
      end
      n_tests++;
      if (mon_a.tstate !== mon_e.tstate) begin
        n_fail++;
        $display("FAIL tstate cyc=%0d actual=%b required=%b", cyc, mon_a.tstate, mon_e.tstate);
      end
      n_tests++;
      if ($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) > 1) begin
        n_fail++;
        $display("FAIL one_oe cyc=%0d actual=%b required=at most one set",
                 cyc, {pc_oe, ram_oe, ir_oe, a_oe, alu_oe});
      end
      n_tests++;
      if ((pc_en & pc_we) !== 1'b0) begin
        n_fail++;
        $display("FAIL pc_en_we cyc=%0d actual=%b%b required=not both", cyc, pc_en, pc_we);
      end
    end
  end

  logic [3:0] cur_op;

  initial begin
    RESET = 1'b1; run = 1'b0; step = 1'b0; opcode = 4'h0;
    carry_flag = 1'b0; zero_flag = 1'b0;
    @(posedge CLK); #1;
    m_t = 1; m_halt = 1'b0; m_stepq = 1'b0;

    cycle(1, 0, 0, 4'h0, 0, 0);
    // LDA free-run, one full instruction plus wrap to T1
    repeat (7) cycle(0, 1, 0, 4'h0, 0, 0);
    // realign and run SUB
    cycle(1, 0, 0, 4'h2, 0, 0);
    repeat (6) cycle(0, 1, 0, 4'h2, 1, 1);
    // JZ with zero clear, then set
    repeat (6) cycle(0, 1, 0, 4'h5, 1, 0);
    repeat (6) cycle(0, 1, 0, 4'h5, 0, 1);
    // JMP, JC taken, OUT, NOP
    repeat (6) cycle(0, 1, 0, 4'h3, 0, 0);
    repeat (6) cycle(0, 1, 0, 4'h4, 1, 0);
    repeat (6) cycle(0, 1, 0, 4'hE, 0, 0);
    repeat (6) cycle(0, 1, 0, 4'h7, 1, 1);
    // single-step from T2: held step advances once, next edge advances again
    cycle(0, 1, 0, 4'h0, 0, 0);
    repeat (5) cycle(0, 0, 1, 4'h0, 0, 0);
    repeat (2) cycle(0, 0, 0, 4'h0, 0, 0);
    repeat (3) cycle(0, 0, 1, 4'h0, 0, 0);
    // finish instruction, then HLT
    repeat (3) cycle(0, 1, 0, 4'h0, 0, 0);
    repeat (4) cycle(0, 1, 0, 4'hF, 0, 0);
    repeat (20) cycle(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
    cycle(1, 1, 0, 4'hF, 0, 0);
    // reset during T5 of ADD
    repeat (4) cycle(0, 1, 0, 4'h1, 0, 0);
    cycle(1, 1, 0, 4'h1, 0, 0);
    repeat (3) cycle(0, 1, 0, 4'h1, 0, 0);

    // Random phase
    cur_op = 4'h0;
    for (int i = 0; i < 1500; i++) begin
      if (m_t == 1) cur_op = 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
            1'($urandom_range(0, 1)), cur_op,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(negedge CLK); #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d required=0 entries left", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Controller/sequencer directly upstream of the program counter, MAR, RAM, IR, A/B registers, ALU and output register of the 4-bit-address computer.
- Steps a T-state ring (T1..T6) and decodes the IR opcode plus ALU flags into the per-cycle control word.
- The control word includes the PC's count enable, bus-output enable and bus-load strobes.
- Supports free-run and single-step operation and latches a halt on HLT.

Parameters:
- OPCODE_W, 4, width of opcode field from IR upper nibble
- NUM_T, 6, T-states per instruction; fixed at 6; values other than 6 are illegal (elaboration error)

Ports:
- CLK  input  1  system clock; all state changes on rising edge
- RESET  input  1  synchronous, active-high reset
- opcode  input  OPCODE_W  IR upper nibble; stable from T4 onward
- carry_flag  input  1  ALU carry from last ADD/SUB
- zero_flag  input  1  ALU zero from last ADD/SUB
- run  input  1  1 = free-run, 0 = single-step
- step  input  1  single-step request; level, edge-detected internally
- pc_en  output  1  PC count enable
- pc_oe  output  1  PC drives bus
- pc_we  output  1  PC loads from bus (jump)
- mar_we  output  1  MAR loads from bus
- ram_oe  output  1  RAM drives bus
- ir_we  output  1  IR loads from bus
- ir_oe  output  1  IR operand nibble drives bus
- a_we  output  1  A loads from bus
- a_oe  output  1  A drives bus
- b_we  output  1  B loads from bus
- alu_sub  output  1  ALU subtract select
- alu_oe  output  1  ALU drives bus
- out_we  output  1  output register loads from bus
- halted  output  1  high while in HALTED state
- tstate  output  NUM_T  one-hot current T-state; all zeros when halted

Behaviour:
- States: T1..T6 (one-hot) plus HALTED.
- On a clock edge with RESET=1: state := T1, step_q := 0.
- While RESET=1, all control outputs and halted are forced to 0; tstate shows T1 after the first reset edge.
- adv = run | (step & ~step_q); step_q is registered step. Exactly one advance per 0->1 transition of step when run=0.
- Transitions on a clock edge with adv=1: Tn -> Tn+1, T6 -> T1.
- Halt transition: T4 with opcode=HLT -> HALTED. HALTED is left only by RESET; run and step are ignored while halted.
- adv=0: state holds.
- Control word is combinational from state, opcode and flags; no extra latency. An instruction takes exactly 6 advancing cycles.
- Strobe gating: state-changing strobes (pc_en, pc_we, mar_we, ir_we, a_we, b_we, out_we) are ANDed with adv. Holding a state never double-increments or double-loads. Output enables and alu_sub are not gated.
- Fetch cycle:
  - T1: pc_oe, mar_we
  - T2: pc_en
  - T3: ram_oe, ir_we
- Execute cycle (T4/T5/T6; unlisted cycles drive nothing):
  - LDA 0000: T4 ir_oe,mar_we; T5 ram_oe,a_we
  - ADD 0001: T4 ir_oe,mar_we; T5 ram_oe,b_we; T6 alu_oe,a_we
  - SUB 0010: as ADD, plus alu_sub in T5 and T6
  - JMP 0011: T4 ir_oe,pc_we
  - JC 0100: T4 ir_oe,pc_we only if carry_flag=1; otherwise nothing
  - JZ 0101: as JC using zero_flag
  - OUT 1110: T4 a_oe,out_we
  - HLT 1111: no strobes
  - all other opcodes: NOP
- Flags are sampled combinationally in T4.
- Invariants:
  - At most one *_oe high in any cycle.
  - pc_en and pc_we are never high together.
  - RESET mid-instruction abandons the instruction with no partial strobes in the following cycle.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT)
  - T-state one-hot constants
  - control-word bit indices
- One sub-module: step_edge (registers step, emits a single-cycle pulse; cleared by RESET). The decode table stays in control_sequencer.

Test Plan:
- Reset then run=1, opcode=0000 (LDA):
  - tstate sequence 000001, 000010, ..., 100000, 000001.
  - pc_oe and mar_we in T1 only; pc_en in T2 only.
  - ram_oe and ir_we in T3; mar_we and ir_oe in T4; ram_oe and a_we in T5.
- run=1, opcode=0010 (SUB):
  - alu_sub high in T5 and T6.
  - alu_oe and a_we in T6 only.
  - b_we in T5 only.
- opcode=0101 (JZ), zero_flag=0 then 1:
  - pass 1: no pc_we in T4.
  - pass 2: ir_oe and pc_we high in T4.
  - pc_en never coincides with pc_we.
- run=0, hold step=1 for 5 cycles in T2:
  - pc_en high for exactly 1 cycle.
  - state advances to T3 once, then holds.
  - a second 0->1 step edge advances to T4.
- opcode=1111 at T4: halted=1 and tstate=0 from the next cycle; 20 cycles of run=1/step toggling leave state unchanged and all strobes 0.
- Assert RESET for 1 cycle during T5 of ADD:
  - all strobes 0 in the reset cycle.
  - next cycle is T1 with pc_oe and mar_we.
  - halted=0 after reset from HALTED.
